// File: rtl/t09_ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// t09_ssd_scan_driver
//
// Converts a binary score to BCD one bit per clock (double-dabble) and drives
// a time-multiplexed seven-segment display. The display register bcd_o is only
// replaced when a conversion completes, so the scan never shows a half-built
// value. Values that do not fit in DIGITS decimal digits saturate to all nines.
// Further features: leading-zero blanking, blinking, and a one-deep load queue
// that keeps only the most recent request made while busy.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   en           block enable (scan counters, new loads, segment output)
//   value_i      binary value to convert
//   load_i       single-cycle request to convert value_i
//   blank_lz_i   blank leading zero digits (digit 0 is always shown)
//   blink_i      gate segments with the free-running blink phase
//   busy_o       conversion in progress
//   done_o       one-cycle pulse when bcd_o/ovf_o update
//   ovf_o        last converted value was >= 10^DIGITS
//   bcd_o        displayed BCD, digit 0 (ones) in bits [3:0]
//   digit_sel_o  index of the digit currently driven
//   seg_o        segments {g,f,e,d,c,b,a}, active high, registered
// ---------------------------------------------------------------------------
module t09_ssd_scan_driver #(
  parameter int DIGITS       = 3,
  parameter int BIN_W        = 8,
  parameter int SCAN_DIV     = 1024,
  parameter int BLINK_FRAMES = 64,
  parameter int SEL_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [BIN_W-1:0]      value_i,
  input  logic                  load_i,
  input  logic                  blank_lz_i,
  input  logic                  blink_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ovf_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [SEL_W-1:0]      digit_sel_o,
  output logic [6:0]            seg_o
);

  localparam int BCD_W   = 4 * DIGITS;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(BIN_W - 1);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0]   SEL_MAX   = SEL_W'(DIGITS - 1);
  localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(BLINK_FRAMES - 1);

  typedef enum logic {
    IDLE,
    CONV
  } state_e;

  // Conversion state
  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;        // remaining value bits, MSB first
  logic [BCD_W-1:0]   work_q, work_d;      // BCD work register
  logic               ovfw_q, ovfw_d;      // sticky overflow of current conversion
  logic [CNT_W-1:0]   cnt_q, cnt_d;        // iteration index
  logic               pend_q, pend_d;
  logic [BIN_W-1:0]   pend_val_q, pend_val_d;

  // Visible result
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  // Scan / blink
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               blink_on_q, blink_on_d;
  logic [6:0]         seg_q, seg_d;

  // Double-dabble step
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;
  logic               shift_out;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  always_comb begin
    adj = work_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (work_q[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
      end
    end
    // The adjusted nibble MSB carries into the next nibble on the shift; the
    // top nibble's MSB has nowhere to go and marks a value too large to show.
    shifted   = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
    shift_out = adj[BCD_W-1];
  end

  // Conversion FSM
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    bin_d      = bin_q;
    work_d     = work_q;
    ovfw_d     = ovfw_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // A fresh request in the done cycle is newer than the queued one.
        if (en && load_i) begin
          bin_d   = value_i;
          work_d  = '0;
          ovfw_d  = 1'b0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = CONV;
        end else if (pend_q) begin
          bin_d   = pend_val_q;
          work_d  = '0;
          ovfw_d  = 1'b0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (en && load_i) begin
          pend_d     = 1'b1;
          pend_val_d = value_i;
        end
        work_d = shifted;
        bin_d  = bin_q << 1;
        ovfw_d = ovfw_q | shift_out;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ovf_d   = ovfw_q | shift_out;
          bcd_d   = (ovfw_q | shift_out) ? {DIGITS{4'h9}} : shifted;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan prescaler, digit select, frame and blink phase
  always_comb begin
    presc_d    = presc_q;
    sel_d      = sel_q;
    frame_d    = frame_q;
    blink_on_d = blink_on_q;
    if (en) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (sel_q == SEL_MAX) begin
          sel_d = '0;
          if (frame_q == FRAME_MAX) begin
            frame_d    = '0;
            blink_on_d = ~blink_on_q;
          end else begin
            frame_d = frame_q + FRAME_W'(1);
          end
        end else begin
          sel_d = sel_q + SEL_W'(1);
        end
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  // Segment output: priority en, blink, leading zero, decode
  logic [DIGITS:0] zero_from;   // zero_from[d]: digits d..DIGITS-1 are all 0
  logic [3:0]      cur_nib;
  logic            lz_blank;

  always_comb begin
    zero_from[DIGITS] = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      zero_from[d] = zero_from[d+1] && (bcd_q[4*d +: 4] == 4'd0);
    end
    cur_nib  = bcd_q[4*int'(sel_q) +: 4];
    lz_blank = blank_lz_i && (sel_q != '0) && zero_from[sel_q];

    seg_d = 7'h00;
    if (!en) begin
      seg_d = 7'h00;
    end else if (blink_i && !blink_on_q) begin
      seg_d = 7'h00;
    end else if (lz_blank) begin
      seg_d = 7'h00;
    end else begin
      seg_d = seg_decode(cur_nib);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      work_q     <= '0;
      ovfw_q     <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      presc_q    <= '0;
      sel_q      <= '0;
      frame_q    <= '0;
      blink_on_q <= 1'b1;
      seg_q      <= 7'h00;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      work_q     <= work_d;
      ovfw_q     <= ovfw_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      presc_q    <= presc_d;
      sel_q      <= sel_d;
      frame_q    <= frame_d;
      blink_on_q <= blink_on_d;
      seg_q      <= seg_d;
    end
  end

  assign busy_o      = (state_q == CONV);
  assign done_o      = done_q;
  assign ovf_o       = ovf_q;
  assign bcd_o       = bcd_q;
  assign digit_sel_o = sel_q;
  assign seg_o       = seg_q;

endmodule

// File: tb/tb_t09_ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_t09_ssd_scan_driver
//
// Directed bench. dut drives a 3-digit display with a short scan (SCAN_DIV=4,
// BLINK_FRAMES=1); dut2 shares all inputs but has only 2 digits so that
// saturation can be exercised with an 8-bit input.
// ---------------------------------------------------------------------------
module tb_t09_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [7:0]  value_i = '0;
  logic        load_i = 1'b0;
  logic        blank_lz_i = 1'b0;
  logic        blink_i = 1'b0;

  logic        busy_o, done_o, ovf_o;
  logic [11:0] bcd_o;
  logic [1:0]  digit_sel_o;
  logic [6:0]  seg_o;

  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
  logic [0:0]  sel2;
  logic [6:0]  seg2;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  t09_ssd_scan_driver #(
    .DIGITS(3), .BIN_W(8), .SCAN_DIV(4), .BLINK_FRAMES(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .value_i(value_i), .load_i(load_i),
    .blank_lz_i(blank_lz_i), .blink_i(blink_i), .busy_o(busy_o),
    .done_o(done_o), .ovf_o(ovf_o), .bcd_o(bcd_o),
    .digit_sel_o(digit_sel_o), .seg_o(seg_o)
  );

  t09_ssd_scan_driver #(
    .DIGITS(2), .BIN_W(8), .SCAN_DIV(4), .BLINK_FRAMES(1)
  ) dut2 (
    .clk(clk), .rst(rst), .en(en), .value_i(value_i), .load_i(load_i),
    .blank_lz_i(blank_lz_i), .blink_i(blink_i), .busy_o(busy2),
    .done_o(done2), .ovf_o(ovf2), .bcd_o(bcd2),
    .digit_sel_o(sel2), .seg_o(seg2)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse load_i for one cycle; returns in the first cycle after the request.
  task automatic do_load(input logic [7:0] v);
    value_i = v;
    load_i  = 1'b1;
    tick();
    load_i  = 1'b0;
  endtask

  // Load and wait (bounded) until done_o is high.
  task automatic convert(input logic [7:0] v);
    bit seen = 1'b0;
    do_load(v);
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done_o) seen = 1'b1;
      else tick();
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_mis++;
      $display("FAIL convert_timeout value=%0d: done seen=%0b, required 1", v, seen);
    end
  endtask

  // Wait (bounded) until digit d is selected, then return the segment value
  // registered for it one cycle later.
  task automatic seg_of_digit(input logic [1:0] d, output logic [6:0] s);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (digit_sel_o == d) seen = 1'b1;
      else tick();
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_mis++;
      $display("FAIL sel_timeout digit=%0d: not selected within bound", d);
    end
    tick();
    s = seg_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (busy_o !== 1'b0)       begin n_mis++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0)       begin n_mis++; $display("FAIL reset_done: got %b, required 0", done_o); end
    n_cmp++; if (ovf_o !== 1'b0)        begin n_mis++; $display("FAIL reset_ovf: got %b, required 0", ovf_o); end
    n_cmp++; if (bcd_o !== 12'h000)     begin n_mis++; $display("FAIL reset_bcd: got %h, required 000", bcd_o); end
    n_cmp++; if (digit_sel_o !== 2'd0)  begin n_mis++; $display("FAIL reset_sel: got %0d, required 0", digit_sel_o); end
    n_cmp++; if (seg_o !== 7'h00)       begin n_mis++; $display("FAIL reset_seg: got %h, required 00", seg_o); end
    rst = 1'b0;
  endtask

  task automatic test_basic_conversion();
    do_load(8'd123);
    for (int i = 1; i <= 8; i++) begin
      n_cmp++;
      if ({busy_o, done_o} !== 2'b10) begin
        n_mis++;
        $display("FAIL basic_busy cycle N+%0d: busy,done=%b, required 10", i, {busy_o, done_o});
      end
      tick();
    end
    n_cmp++; if ({busy_o, done_o} !== 2'b01) begin n_mis++; $display("FAIL basic_done: busy,done=%b, required 01", {busy_o, done_o}); end
    n_cmp++; if (bcd_o !== 12'h123) begin n_mis++; $display("FAIL basic_bcd: got %h, required 123", bcd_o); end
    n_cmp++; if (ovf_o !== 1'b0)    begin n_mis++; $display("FAIL basic_ovf: got %b, required 0", ovf_o); end
    tick();
    n_cmp++; if (done_o !== 1'b0)   begin n_mis++; $display("FAIL basic_done_pulse: got %b, required 0", done_o); end
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [3] = '{7'h4F, 7'h5B, 7'h06};
    logic [1:0] prev;
    logic [1:0] exp_sel;
    bit         found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      prev = digit_sel_o;
      tick();
      if (prev == 2'd2 && digit_sel_o == 2'd0) found = 1'b1;
    end
    n_cmp++;
    if (found !== 1'b1) begin n_mis++; $display("FAIL scan_sync: no 2->0 select wrap within bound"); end
    for (int k = 0; k < 6; k++) begin
      exp_sel = 2'(k % 3);
      n_cmp++;
      if (digit_sel_o !== exp_sel) begin
        n_mis++;
        $display("FAIL scan_sel step %0d: got %0d, required %0d", k, digit_sel_o, exp_sel);
      end
      tick();
      n_cmp++;
      if (seg_o !== exp_seg[exp_sel]) begin
        n_mis++;
        $display("FAIL scan_seg step %0d: got %h, required %h", k, seg_o, exp_seg[exp_sel]);
      end
      tick();
      tick();
      tick();
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] s;
    convert(8'd7);
    blank_lz_i = 1'b1;
    seg_of_digit(2'd0, s);
    n_cmp++; if (s !== 7'h07) begin n_mis++; $display("FAIL lz7_d0: got %h, required 07", s); end
    seg_of_digit(2'd1, s);
    n_cmp++; if (s !== 7'h00) begin n_mis++; $display("FAIL lz7_d1: got %h, required 00", s); end
    seg_of_digit(2'd2, s);
    n_cmp++; if (s !== 7'h00) begin n_mis++; $display("FAIL lz7_d2: got %h, required 00", s); end
    blank_lz_i = 1'b0;
    seg_of_digit(2'd1, s);
    n_cmp++; if (s !== 7'h3F) begin n_mis++; $display("FAIL nolz7_d1: got %h, required 3F", s); end
    seg_of_digit(2'd2, s);
    n_cmp++; if (s !== 7'h3F) begin n_mis++; $display("FAIL nolz7_d2: got %h, required 3F", s); end
    blank_lz_i = 1'b1;
    convert(8'd100);
    n_cmp++; if (bcd_o !== 12'h100) begin n_mis++; $display("FAIL lz100_bcd: got %h, required 100", bcd_o); end
    seg_of_digit(2'd0, s);
    n_cmp++; if (s !== 7'h3F) begin n_mis++; $display("FAIL lz100_d0: got %h, required 3F", s); end
    seg_of_digit(2'd1, s);
    n_cmp++; if (s !== 7'h3F) begin n_mis++; $display("FAIL lz100_d1: got %h, required 3F", s); end
    seg_of_digit(2'd2, s);
    n_cmp++; if (s !== 7'h06) begin n_mis++; $display("FAIL lz100_d2: got %h, required 06", s); end
    blank_lz_i = 1'b0;
  endtask

  task automatic test_overflow();
    convert(8'd200);
    n_cmp++; if (done2 !== 1'b1)  begin n_mis++; $display("FAIL ovf200_done2: got %b, required 1", done2); end
    n_cmp++; if (ovf2 !== 1'b1)   begin n_mis++; $display("FAIL ovf200_ovf2: got %b, required 1", ovf2); end
    n_cmp++; if (bcd2 !== 8'h99)  begin n_mis++; $display("FAIL ovf200_bcd2: got %h, required 99", bcd2); end
    n_cmp++; if (bcd_o !== 12'h200) begin n_mis++; $display("FAIL ovf200_bcd3: got %h, required 200", bcd_o); end
    n_cmp++; if (ovf_o !== 1'b0)  begin n_mis++; $display("FAIL ovf200_ovf3: got %b, required 0", ovf_o); end
    convert(8'd42);
    n_cmp++; if (ovf2 !== 1'b0)   begin n_mis++; $display("FAIL ovf42_ovf2: got %b, required 0", ovf2); end
    n_cmp++; if (bcd2 !== 8'h42)  begin n_mis++; $display("FAIL ovf42_bcd2: got %h, required 42", bcd2); end
  endtask

  task automatic test_back_to_back();
    int          n_done = 0;
    int          done_at [2] = '{0, 0};
    logic [11:0] done_bcd [2] = '{12'h000, 12'h000};
    bit          seen20 = 1'b0;
    logic        busy_at10 = 1'b0;
    tick();
    do_load(8'd10);
    for (int i = 1; i <= 25; i++) begin
      if (i == 3) begin value_i = 8'd20; load_i = 1'b1; end
      else if (i == 5) begin value_i = 8'd30; load_i = 1'b1; end
      else load_i = 1'b0;
      if (done_o) begin
        if (n_done < 2) begin
          done_at[n_done]  = i;
          done_bcd[n_done] = bcd_o;
        end
        n_done++;
      end
      if (bcd_o == 12'h020) seen20 = 1'b1;
      if (i == 10) busy_at10 = busy_o;
      tick();
    end
    load_i = 1'b0;
    n_cmp++; if (n_done !== 2)          begin n_mis++; $display("FAIL queue_done_count: got %0d, required 2", n_done); end
    n_cmp++; if (done_bcd[0] !== 12'h010) begin n_mis++; $display("FAIL queue_first_bcd: got %h, required 010", done_bcd[0]); end
    n_cmp++; if (done_bcd[1] !== 12'h030) begin n_mis++; $display("FAIL queue_second_bcd: got %h, required 030", done_bcd[1]); end
    n_cmp++; if (done_at[0] !== 9)      begin n_mis++; $display("FAIL queue_first_time: got N+%0d, required N+9", done_at[0]); end
    n_cmp++; if (done_at[1] !== 18)     begin n_mis++; $display("FAIL queue_second_time: got N+%0d, required N+18", done_at[1]); end
    n_cmp++; if (busy_at10 !== 1'b1)    begin n_mis++; $display("FAIL queue_restart_busy: got %b, required 1", busy_at10); end
    n_cmp++; if (seen20 !== 1'b0)       begin n_mis++; $display("FAIL queue_stale_shown: 020 displayed=%b, required 0", seen20); end
  endtask

  task automatic test_reset_mid_conversion();
    bit any_done = 1'b0;
    do_load(8'd55);
    tick();
    tick();
    tick();
    n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL rstmid_busy4: got %b, required 1", busy_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy_o, done_o, ovf_o, bcd_o, digit_sel_o, seg_o} !== '0) begin
      n_mis++;
      $display("FAIL rstmid_outputs: busy=%b done=%b ovf=%b bcd=%h sel=%0d seg=%h, required all 0",
               busy_o, done_o, ovf_o, bcd_o, digit_sel_o, seg_o);
    end
    for (int i = 0; i < 12; i++) begin
      if (done_o) any_done = 1'b1;
      tick();
    end
    n_cmp++; if (any_done !== 1'b0) begin n_mis++; $display("FAIL rstmid_no_done: got done pulse, required none"); end
    n_cmp++; if (bcd_o !== 12'h000) begin n_mis++; $display("FAIL rstmid_bcd: got %h, required 000", bcd_o); end
  endtask

  task automatic test_enable();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (digit_sel_o !== 2'd1) begin n_mis++; $display("FAIL en_sel_before: got %0d, required 1", digit_sel_o); end
    en = 1'b0;
    tick();
    n_cmp++; if (seg_o !== 7'h00) begin n_mis++; $display("FAIL en_seg_off: got %h, required 00", seg_o); end
    do_load(8'd77);
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL en_load_ignored: busy=%b, required 0", busy_o); end
    for (int i = 0; i < 8; i++) tick();
    n_cmp++; if (digit_sel_o !== 2'd1) begin n_mis++; $display("FAIL en_sel_frozen: got %0d, required 1", digit_sel_o); end
    n_cmp++; if (seg_o !== 7'h00)      begin n_mis++; $display("FAIL en_seg_held: got %h, required 00", seg_o); end
    en = 1'b1;
    tick();
    n_cmp++; if (seg_o !== 7'h3F)      begin n_mis++; $display("FAIL en_seg_restored: got %h, required 3F", seg_o); end
    tick();
    n_cmp++; if (digit_sel_o !== 2'd1) begin n_mis++; $display("FAIL en_sel_resume1: got %0d, required 1", digit_sel_o); end
    tick();
    n_cmp++; if (digit_sel_o !== 2'd2) begin n_mis++; $display("FAIL en_sel_resume2: got %0d, required 2", digit_sel_o); end
  endtask

  task automatic test_blink();
    logic [6:0] exp;
    blink_i = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      exp = (k <= 12) ? 7'h3F : 7'h00;
      n_cmp++;
      if (seg_o !== exp) begin
        n_mis++;
        $display("FAIL blink_seg cycle %0d: got %h, required %h", k, seg_o, exp);
      end
    end
    blink_i = 1'b0;
    tick();
    n_cmp++; if (seg_o !== 7'h3F) begin n_mis++; $display("FAIL blink_release: got %h, required 3F", seg_o); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_conversion();
    test_scan();
    test_leading_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid_conversion();
    test_enable();
    test_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
